// File: rtl/ula_pkg.sv
// Shared types for the execute-stage ALU sequencer: opcodes, flag classes, FSM states.
package ula_pkg;

   localparam logic [4:0] OP_SOMA     = 5'b00000;
   localparam logic [4:0] OP_DESL_ESQ = 5'b01000;
   localparam logic [4:0] OP_DESL_DIR = 5'b01001;
   localparam logic [4:0] OP_ZERO     = 5'b10000;
   localparam logic [4:0] OP_PASSA_B  = 5'b10011;

   typedef enum logic [1:0] {TODAS, SCZ, SZ, NENHUMA} classe_flags_t;

   typedef enum logic [2:0] {OCIOSO, LEITURA, EXECUTA, ESCRITA, ERRO} estado_t;

   function automatic logic eh_deslocamento(input logic [4:0] op);
      return (op == OP_DESL_ESQ) || (op == OP_DESL_DIR);
   endfunction

endpackage

// File: rtl/ula_sequenciador_if.sv
// Decode-to-execute instruction handshake; decode side is master, sequencer is slave.
// With ULA_IMEDIATO_EN the bus also carries an optional immediate for operand B.
interface ula_sequenciador_if #(
   parameter int BITS_REG = 3
`ifdef ULA_IMEDIATO_EN
   , parameter int BITS_PALAVRA = 16
`endif
) ();

   logic                inst_valida;
   logic                inst_pronta;
   logic [4:0]          inst_op;
   logic [BITS_REG-1:0] inst_rd;
   logic [BITS_REG-1:0] inst_ra;
   logic [BITS_REG-1:0] inst_rb;
   logic [3:0]          inst_desl;
`ifdef ULA_IMEDIATO_EN
   logic                    inst_usa_imediato;
   logic [BITS_PALAVRA-1:0] inst_imediato;
`endif

   modport master (
      output inst_valida, inst_op, inst_rd, inst_ra, inst_rb, inst_desl,
`ifdef ULA_IMEDIATO_EN
      output inst_usa_imediato, inst_imediato,
`endif
      input  inst_pronta
   );

   modport slave (
      input  inst_valida, inst_op, inst_rd, inst_ra, inst_rb, inst_desl,
`ifdef ULA_IMEDIATO_EN
      input  inst_usa_imediato, inst_imediato,
`endif
      output inst_pronta
   );

endinterface

// File: rtl/ula_classe_flags.sv
// Combinational opcode decoder: flag-update class and opcode legality (also used by decode).
// Zero latency, no handshake.
module ula_classe_flags
   import ula_pkg::*;
(
   input  logic [4:0]    op,
   output classe_flags_t classe,
   output logic          legal
);

   always_comb begin
      classe = NENHUMA;
      legal  = 1'b1;
      case (op)
         OP_SOMA, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110:
            classe = TODAS;
         OP_DESL_ESQ, OP_DESL_DIR:
            classe = SCZ;
         OP_ZERO, OP_PASSA_B, 5'b11111:
            classe = NENHUMA;
         5'b00010, 5'b00111, 5'b01010, 5'b01011,
         5'b01100, 5'b01101, 5'b01110, 5'b01111:
            legal = 1'b0;
         // every remaining encoding is 1xxxx and updates S and Z only
         default:
            classe = SZ;
      endcase
   end

endmodule

// File: rtl/ula_sequenciador.sv
// Sequences the shared ALU for one instruction: read, execute (1-bit shift steps), write back, flags.
// Retire at T+3 (shift N: T+2+N, illegal: T+1); busy means inst_pronta low. Option: ULA_IMEDIATO_EN.
module ula_sequenciador
   import ula_pkg::*;
#(
   parameter int BITS_PALAVRA = 16,
   parameter int BITS_REG     = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   ula_sequenciador_if.slave       inst,
   output logic [BITS_REG-1:0]     rf_end_a,
   output logic [BITS_REG-1:0]     rf_end_b,
   input  logic [BITS_PALAVRA-1:0] rf_dado_a,
   input  logic [BITS_PALAVRA-1:0] rf_dado_b,
   output logic                    rf_escrita,
   output logic [BITS_REG-1:0]     rf_end_escrita,
   output logic [BITS_PALAVRA-1:0] rf_dado_escrita,
   output logic [BITS_PALAVRA-1:0] ula_operandoA,
   output logic [BITS_PALAVRA-1:0] ula_operandoB,
   output logic [4:0]              ula_controle,
   input  logic [BITS_PALAVRA-1:0] ula_resultado,
   input  logic                    ula_Z,
   input  logic                    ula_C,
   input  logic                    ula_S,
   input  logic                    ula_O,
   output logic                    flag_Z,
   output logic                    flag_C,
   output logic                    flag_S,
   output logic                    flag_O,
   output logic                    concluido,
   output logic                    erro
);

   estado_t             estado, prox;
   classe_flags_t       classe_in, classe_r;
   logic                legal_in;
   logic [4:0]          op_r;
   logic [BITS_REG-1:0] rd_r, ra_r, rb_r;
   logic [3:0]          cont_r;
   logic [BITS_PALAVRA-1:0] opa_r, opb_r, res_r;
   logic                amo_z, amo_c, amo_s, amo_o;
   logic                aceita, desloca_mais;
   logic                en_zs, en_c, en_o;
   logic [BITS_REG-1:0] end_b_in, end_b_r;
   logic [BITS_PALAVRA-1:0] dado_b;
`ifdef ULA_IMEDIATO_EN
   logic                    usa_imm_r;
   logic [BITS_PALAVRA-1:0] imm_r;
`endif

   ula_classe_flags u_classe (
      .op     (inst.inst_op),
      .classe (classe_in),
      .legal  (legal_in)
   );

   assign aceita       = (estado == OCIOSO) && inst.inst_valida;
   assign desloca_mais = eh_deslocamento(op_r) && (cont_r > 4'd1);

   assign en_zs = (classe_r != NENHUMA);
   assign en_c  = (classe_r == TODAS) || (classe_r == SCZ);
   assign en_o  = (classe_r == TODAS);

`ifdef ULA_IMEDIATO_EN
   assign end_b_in = inst.inst_usa_imediato ? '0 : inst.inst_rb;
   assign end_b_r  = usa_imm_r ? '0 : rb_r;
   assign dado_b   = usa_imm_r ? imm_r : rf_dado_b;
`else
   assign end_b_in = inst.inst_rb;
   assign end_b_r  = rb_r;
   assign dado_b   = rf_dado_b;
`endif

   always_ff @(posedge clock) begin
      if (reset) estado <= OCIOSO;
      else       estado <= prox;
   end

   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:  if (inst.inst_valida) prox = legal_in ? LEITURA : ERRO;
         LEITURA: prox = EXECUTA;
         EXECUTA: prox = desloca_mais ? EXECUTA : ESCRITA;
         ESCRITA: prox = OCIOSO;
         ERRO:    prox = OCIOSO;
         default: prox = OCIOSO;
      endcase
   end

   always_comb begin
      inst.inst_pronta = 1'b0;
      rf_escrita       = 1'b0;
      concluido        = 1'b0;
      erro             = 1'b0;
      ula_operandoA    = '0;
      ula_operandoB    = '0;
      ula_controle     = OP_ZERO;
      // addresses come straight from the bus while idle so read data is ready in LEITURA
      rf_end_a = (estado == OCIOSO) ? inst.inst_ra : ra_r;
      rf_end_b = (estado == OCIOSO) ? end_b_in : end_b_r;
      if (!reset) begin
         inst.inst_pronta = (estado == OCIOSO);
         rf_escrita       = (estado == ESCRITA);
         concluido        = (estado == ESCRITA) || (estado == ERRO);
         erro             = (estado == ERRO);
         if (estado == EXECUTA) begin
            ula_operandoA = opa_r;
            ula_operandoB = opb_r;
            ula_controle  = op_r;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         op_r     <= OP_ZERO;
         classe_r <= NENHUMA;
         rd_r     <= '0;
         ra_r     <= '0;
         rb_r     <= '0;
         cont_r   <= '0;
         opa_r    <= '0;
         opb_r    <= '0;
         res_r    <= '0;
         amo_z    <= 1'b0;
         amo_c    <= 1'b0;
         amo_s    <= 1'b0;
         amo_o    <= 1'b0;
         flag_Z   <= 1'b0;
         flag_C   <= 1'b0;
         flag_S   <= 1'b0;
         flag_O   <= 1'b0;
`ifdef ULA_IMEDIATO_EN
         usa_imm_r <= 1'b0;
         imm_r     <= '0;
`endif
      end else begin
         if (aceita) begin
            op_r     <= inst.inst_op;
            classe_r <= classe_in;
            rd_r     <= inst.inst_rd;
            ra_r     <= inst.inst_ra;
            rb_r     <= inst.inst_rb;
            cont_r   <= (inst.inst_desl == 4'd0) ? 4'd1 : inst.inst_desl;
`ifdef ULA_IMEDIATO_EN
            usa_imm_r <= inst.inst_usa_imediato;
            imm_r     <= inst.inst_imediato;
`endif
         end
         if (estado == LEITURA) begin
            opa_r <= rf_dado_a;
            opb_r <= dado_b;
         end
         if (estado == EXECUTA) begin
            res_r <= ula_resultado;
            amo_z <= ula_Z;
            amo_c <= ula_C;
            amo_s <= ula_S;
            amo_o <= ula_O;
            if (desloca_mais) begin
               opa_r  <= ula_resultado;
               cont_r <= cont_r - 4'd1;
            end
         end
         if (estado == ESCRITA) begin
            if (en_zs) begin
               flag_Z <= amo_z;
               flag_S <= amo_s;
            end
            if (en_c) flag_C <= amo_c;
            if (en_o) flag_O <= amo_o;
         end
      end
   end

   assign rf_end_escrita  = rd_r;
   assign rf_dado_escrita = res_r;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Bench for ula_sequenciador: register file and ALU models, directed vectors, queue-based scoreboard.
module tb_ula_sequenciador;

   localparam int BP = 16;
   localparam int BR = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [BR-1:0] rf_end_a, rf_end_b, rf_end_escrita;
   logic [BP-1:0] rf_dado_a, rf_dado_b, rf_dado_escrita;
   logic          rf_escrita;
   logic [BP-1:0] ula_operandoA, ula_operandoB, ula_resultado;
   logic [4:0]    ula_controle;
   logic          ula_Z, ula_C, ula_S, ula_O;
   logic          flag_Z, flag_C, flag_S, flag_O;
   logic          concluido, erro;

   int cyc    = 0;
   int n_vec  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   ula_sequenciador_if #(.BITS_REG(BR)) ib ();

`ifdef ULA_IMEDIATO_EN
   initial begin
      ib.inst_usa_imediato = 1'b0;
      ib.inst_imediato     = '0;
   end
`endif

   ula_sequenciador #(.BITS_PALAVRA(BP), .BITS_REG(BR)) dut (
      .clock           (clock),
      .reset           (reset),
      .inst            (ib),
      .rf_end_a        (rf_end_a),
      .rf_end_b        (rf_end_b),
      .rf_dado_a       (rf_dado_a),
      .rf_dado_b       (rf_dado_b),
      .rf_escrita      (rf_escrita),
      .rf_end_escrita  (rf_end_escrita),
      .rf_dado_escrita (rf_dado_escrita),
      .ula_operandoA   (ula_operandoA),
      .ula_operandoB   (ula_operandoB),
      .ula_controle    (ula_controle),
      .ula_resultado   (ula_resultado),
      .ula_Z           (ula_Z),
      .ula_C           (ula_C),
      .ula_S           (ula_S),
      .ula_O           (ula_O),
      .flag_Z          (flag_Z),
      .flag_C          (flag_C),
      .flag_S          (flag_S),
      .flag_O          (flag_O),
      .concluido       (concluido),
      .erro            (erro)
   );

   // register file: synchronous read, preload port used only while the DUT is idle
   logic [BP-1:0] regs [8];
   logic          pre_en = 1'b0;
   logic [BR-1:0] pre_end = '0;
   logic [BP-1:0] pre_dado = '0;

   always @(posedge clock) begin
      if (pre_en) regs[pre_end] <= pre_dado;
      else if (rf_escrita) regs[rf_end_escrita] <= rf_dado_escrita;
      rf_dado_a <= regs[rf_end_a];
      rf_dado_b <= regs[rf_end_b];
   end

   logic [16:0] soma;
   always_comb begin
      soma          = {1'b0, ula_operandoA} + {1'b0, ula_operandoB};
      ula_resultado = '0;
      ula_C         = 1'b0;
      ula_O         = 1'b0;
      case (ula_controle)
         5'b00000: begin
            ula_resultado = soma[15:0];
            ula_C         = soma[16];
            ula_O         = (ula_operandoA[15] == ula_operandoB[15]) && (soma[15] != ula_operandoA[15]);
         end
         5'b01000: begin
            ula_resultado = {ula_operandoA[14:0], 1'b0};
            ula_C         = ula_operandoA[15];
         end
         5'b01001: begin
            ula_resultado = {1'b0, ula_operandoA[15:1]};
            ula_C         = ula_operandoA[0];
         end
         5'b10001: ula_resultado = ula_operandoA & ula_operandoB;
         5'b10011: ula_resultado = ula_operandoB;
         default:  ula_resultado = '0;
      endcase
   end
   assign ula_Z = (ula_resultado == '0);
   assign ula_S = ula_resultado[15];

   typedef struct {
      logic [4:0]  op;
      logic [2:0]  rd, ra, rb;
      logic [3:0]  desl;
      logic [15:0] dado;
      int          lat;
      bit          err;
      logic [3:0]  fl;   // {Z, C, S, O} after retire
   } vet_t;

   typedef struct {
      int          t;
      bit          err;
      logic [2:0]  rd;
      logic [15:0] dado;
      logic [3:0]  fl;
   } esp_t;

   esp_t fila[$];

   task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] esp);
      n_vec++;
      if (atual !== esp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nome, atual, esp, cyc);
      end
   endtask

   task automatic carrega(input logic [2:0] e, input logic [15:0] d);
      @(negedge clock);
      pre_en   = 1'b1;
      pre_end  = e;
      pre_dado = d;
      @(negedge clock);
      pre_en   = 1'b0;
   endtask

   task automatic emite(input vet_t v, input bit regista);
      int guarda;
      @(negedge clock);
      ib.inst_valida = 1'b1;
      ib.inst_op     = v.op;
      ib.inst_rd     = v.rd;
      ib.inst_ra     = v.ra;
      ib.inst_rb     = v.rb;
      ib.inst_desl   = v.desl;
      guarda = 0;
      while (!ib.inst_pronta && guarda < 200) begin
         @(negedge clock);
         guarda++;
      end
      if (!ib.inst_pronta) confere("timeout_aceite", 32'(ib.inst_pronta), 1);
      else if (regista) fila.push_back('{cyc + v.lat, v.err, v.rd, v.dado, v.fl});
      @(posedge clock);
   endtask

   task automatic solta();
      @(negedge clock);
      ib.inst_valida = 1'b0;
   endtask

   task automatic aguarda_ocioso();
      int guarda = 0;
      while (fila.size() != 0 && guarda < 300) begin
         @(negedge clock);
         guarda++;
      end
      if (fila.size() != 0) confere("timeout_fila", 32'(fila.size()), 0);
      repeat (2) @(negedge clock);
   endtask

   // scoreboard monitor
   initial begin
      esp_t e;
      forever begin
         @(negedge clock);
         if (concluido) begin
            if (fila.size() == 0) begin
               confere("concluido_inesperado", 32'(concluido), 0);
            end else begin
               e = fila.pop_front();
               confere("latencia", 32'(cyc), 32'(e.t));
               confere("erro", 32'(erro), 32'(e.err));
               confere("escrita", 32'(rf_escrita), 32'(!e.err));
               if (!e.err) begin
                  confere("end_escrita", 32'(rf_end_escrita), 32'(e.rd));
                  confere("dado_escrita", 32'(rf_dado_escrita), 32'(e.dado));
               end
               @(negedge clock);
               confere("flags", 32'({flag_Z, flag_C, flag_S, flag_O}), 32'(e.fl));
               confere("pronta_apos", 32'(ib.inst_pronta), 1);
            end
         end else if (rf_escrita || erro) begin
            confere("pulso_sem_concluido", 32'({rf_escrita, erro}), 0);
         end
      end
   end

   vet_t tab [12];
   vet_t vr;

   initial begin
      //            op        rd    ra    rb    desl   dado      lat err fl{ZCSO}
      tab[0]  = '{5'b00000, 3'd3, 3'd1, 3'd2, 4'd0, 16'h8000, 3, 0, 4'b0011};
      tab[1]  = '{5'b10011, 3'd4, 3'd0, 3'd3, 4'd0, 16'h8000, 3, 0, 4'b0011};
      tab[2]  = '{5'b01000, 3'd5, 3'd5, 3'd0, 4'd3, 16'h0008, 5, 0, 4'b0001};
      tab[3]  = '{5'b00000, 3'd0, 3'd6, 3'd7, 4'd0, 16'h0001, 3, 0, 4'b0101};
      tab[4]  = '{5'b10001, 3'd3, 3'd1, 3'd2, 4'd0, 16'h0000, 3, 0, 4'b1101};
      tab[5]  = '{5'b10011, 3'd4, 3'd0, 3'd7, 4'd0, 16'h1234, 3, 0, 4'b1101};
      tab[6]  = '{5'b00010, 3'd1, 3'd1, 3'd1, 4'd0, 16'h0000, 1, 1, 4'b1101};
      tab[7]  = '{5'b01111, 3'd2, 3'd2, 3'd2, 4'd0, 16'h0000, 1, 1, 4'b1101};
      tab[8]  = '{5'b01000, 3'd2, 3'd2, 3'd0, 4'd0, 16'h1E00, 3, 0, 4'b0001};
      tab[9]  = '{5'b10000, 3'd1, 3'd1, 3'd2, 4'd0, 16'h0000, 3, 0, 4'b0001};
      tab[10] = '{5'b01001, 3'd5, 3'd5, 3'd0, 4'd4, 16'h0000, 6, 0, 4'b1101};
      tab[11] = '{5'b00000, 3'd3, 3'd6, 3'd2, 4'd0, 16'h9E00, 3, 0, 4'b0010};
      vr      = '{5'b01000, 3'd6, 3'd1, 3'd0, 4'd5, 16'h0000, 7, 0, 4'b0000};

      ib.inst_valida = 1'b0;
      ib.inst_op     = '0;
      ib.inst_rd     = '0;
      ib.inst_ra     = '0;
      ib.inst_rb     = '0;
      ib.inst_desl   = '0;

      repeat (2) @(negedge clock);
      confere("reset_pronta", 32'(ib.inst_pronta), 0);
      confere("reset_saidas", 32'({rf_escrita, concluido, erro}), 0);
      confere("reset_flags", 32'({flag_Z, flag_C, flag_S, flag_O}), 0);
      confere("reset_controle", 32'(ula_controle), 32'h10);
      confere("reset_operandos", {ula_operandoA, ula_operandoB}, 0);

      for (int i = 0; i < 8; i++) carrega(3'(i), 16'h0000);
      carrega(3'd1, 16'h7FFF);
      carrega(3'd2, 16'h0001);
      carrega(3'd5, 16'hC001);
      carrega(3'd6, 16'h8000);
      carrega(3'd7, 16'h8001);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      confere("pronta_ocioso", 32'(ib.inst_pronta), 1);

      for (int i = 0; i < 4; i++) emite(tab[i], 1'b1);
      solta();
      aguarda_ocioso();

      carrega(3'd1, 16'h00F0);
      carrega(3'd2, 16'h0F00);
      carrega(3'd7, 16'h1234);
      for (int i = 4; i < 11; i++) emite(tab[i], 1'b1);
      solta();
      aguarda_ocioso();

      // reset during the second EXECUTA of a 5-step shift
      emite(vr, 1'b0);
      solta();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      confere("abort_pronta", 32'(ib.inst_pronta), 0);
      confere("abort_saidas", 32'({rf_escrita, concluido, erro}), 0);
      confere("abort_flags", 32'({flag_Z, flag_C, flag_S, flag_O}), 0);
      confere("abort_controle", 32'(ula_controle), 32'h10);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      confere("pos_reset_pronta", 32'(ib.inst_pronta), 1);
      confere("pos_reset_flags", 32'({flag_Z, flag_C, flag_S, flag_O}), 0);

      emite(tab[11], 1'b1);
      solta();
      aguarda_ocioso();
      confere("r6_intacto", 32'(regs[6]), 32'h8000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
